// File: rtl/irq_ctl_pkg.sv
// Shared definitions for the interrupt controller: register map and FSM state encoding.
package irq_ctl_pkg;

  localparam logic [1:0] ADDR_PEND   = 2'd0;
  localparam logic [1:0] ADDR_MASK   = 2'd1;
  localparam logic [1:0] ADDR_BASE   = 2'd2;
  localparam logic [1:0] ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_ctl_if.sv
// Bundle of the source lines, core request/ack handshake and register port.
interface irq_ctl_if #(parameter int N_IRQ = 8);
  logic [N_IRQ-1:0] src_i;
  logic             iack_i;
  logic             irq_o;
  logic [31:0]      irq_addr_o;
  logic [1:0]       reg_addr_i;
  logic             reg_we_i;
  logic [31:0]      reg_wdata_i;
  logic [31:0]      reg_rdata_o;
  logic             busy_o;

  modport master (
    output src_i, iack_i, reg_addr_i, reg_we_i, reg_wdata_i,
    input  irq_o, irq_addr_o, reg_rdata_o, busy_o
  );

  modport slave (
    input  src_i, iack_i, reg_addr_i, reg_we_i, reg_wdata_i,
    output irq_o, irq_addr_o, reg_rdata_o, busy_o
  );
endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder; index 0 has the highest priority.
module irq_prio_enc #(
  parameter int N_IRQ = 8
) (
  input  logic [N_IRQ-1:0] req,
  output logic             valid,
  output logic [3:0]       index
);

  always_comb begin
    valid = |req;
    index = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (req[i]) index = 4'(i);
    end
  end

endmodule

// File: rtl/irq_ctl.sv
// Edge-capturing interrupt controller with mask, fixed priority and a
// request/ack/service/EOI sequence towards a single-input core.
//
// state   | meaning
// IDLE    | arbitrating PEND & MASK each cycle
// REQ     | irq_o high, vector latched, waiting for iack
// SERVICE | handler running, waiting for EOI write to STATUS
module irq_ctl
  import irq_ctl_pkg::*;
#(
  parameter int          N_IRQ     = 8,
  parameter int          VEC_SHIFT = 4,
  parameter logic [31:0] RST_BASE  = 32'h0000_0050
) (
  input logic       clk,
  input logic       rst,
  irq_ctl_if.slave  bus
);

  localparam logic [31:0] BASE_MASK = ~((32'd1 << (VEC_SHIFT + 4)) - 32'd1);

  state_t           state, state_n;
  logic [N_IRQ-1:0] prev, pend, pend_n, mask, edges, cand;
  logic [31:0]      base, vec;
  logic [3:0]       act, win;
  logic             win_vld, eoi, ack;

  assign edges = bus.src_i & ~prev;
  assign cand  = pend & mask;
  assign eoi   = bus.reg_we_i && (bus.reg_addr_i == ADDR_STATUS);
  assign ack   = bus.iack_i && (state == REQ);

  irq_prio_enc #(.N_IRQ(N_IRQ)) u_enc (
    .req   (cand),
    .valid (win_vld),
    .index (win)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (win_vld) state_n = REQ;
      REQ:     if (bus.iack_i) state_n = SERVICE;
      SERVICE: if (eoi) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Priority: software clear < new edge < acknowledge clear of the active source.
  always_comb begin
    pend_n = pend;
    if (bus.reg_we_i && bus.reg_addr_i == ADDR_PEND)
      pend_n = pend_n & ~bus.reg_wdata_i[N_IRQ-1:0];
    pend_n = pend_n | edges;
    if (ack) begin
      for (int k = 0; k < N_IRQ; k++) begin
        if (act == 4'(k)) pend_n[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      prev  <= '0;
      pend  <= '0;
      mask  <= '0;
      base  <= RST_BASE;
      vec   <= RST_BASE;
      act   <= '0;
    end else begin
      state <= state_n;
      prev  <= bus.src_i;
      pend  <= pend_n;
      if (bus.reg_we_i && bus.reg_addr_i == ADDR_MASK) mask <= bus.reg_wdata_i[N_IRQ-1:0];
      if (bus.reg_we_i && bus.reg_addr_i == ADDR_BASE) base <= bus.reg_wdata_i & BASE_MASK;
      if (state == IDLE && win_vld) begin
        act <= win;
        vec <= base + ({28'd0, win} << VEC_SHIFT);
      end
    end
  end

  assign bus.irq_o      = (state == REQ);
  assign bus.busy_o     = (state != IDLE);
  assign bus.irq_addr_o = vec;

  always_comb begin
    bus.reg_rdata_o = '0;
    case (bus.reg_addr_i)
      ADDR_PEND:   bus.reg_rdata_o[N_IRQ-1:0] = pend;
      ADDR_MASK:   bus.reg_rdata_o[N_IRQ-1:0] = mask;
      ADDR_BASE:   bus.reg_rdata_o = base;
      ADDR_STATUS: bus.reg_rdata_o[6:0] = {bus.busy_o, state, act};
      default:     bus.reg_rdata_o = '0;
    endcase
  end

endmodule
